// File: rtl/mont_shift_pkg.sv
// rtl/mont_shift_pkg.sv - shared types and helpers for the Montgomery shift unit
package mont_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Amount field must encode 0..WIDTH+1.
    function automatic int calc_aw(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/mont_shift_stage.sv
// rtl/mont_shift_stage.sv - combinational barrel stage shifting by 0..STEP bits
module mont_shift_stage
    import mont_shift_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH:0]  acc,
    input  logic            dir,
    input  logic [SW-1:0]   s,
    output logic [WIDTH:0]  shifted,
    output logic            lost
);

    // A guard bit below bit 0 catches the last bit shifted out on right shifts.
    logic [WIDTH+1:0] lvl [SW+1];

    assign lvl[0] = {acc, 1'b0};

    for (genvar i = 0; i < SW; i++) begin : g_lvl
        localparam int SH = 1 << i;
        assign lvl[i+1] = !s[i]             ? lvl[i] :
                          (dir == DIR_RIGHT) ? (lvl[i] >> SH) : (lvl[i] << SH);
    end

    assign shifted = lvl[SW][WIDTH+1:1];
    assign lost    = (dir == DIR_RIGHT) & lvl[SW][0];

endmodule

// File: rtl/mont_shift_unit.sv
// rtl/mont_shift_unit.sv - multi-cycle left/right shifter with start/busy/done handshake
module mont_shift_unit
    import mont_shift_pkg::*;
#(
    parameter int WIDTH = 1024,
    parameter int STEP  = 1,
    parameter int AW    = calc_aw(WIDTH)
) (
    input  logic            clk,
    input  logic            restn,
    input  logic            load,
    input  logic [WIDTH-1:0] in_number,
    input  logic            start,
    input  logic            dir,
    input  logic [AW-1:0]   amount,
    output logic            busy,
    output logic [WIDTH:0]  out_shift,
    output logic            lost_bit,
    output logic            shift_done
);

    localparam int SW = $clog2(STEP) + 1;
    localparam logic [AW-1:0] MAX_AMT  = AW'(WIDTH + 1);
    localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

    state_t         state;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] stage_acc;
    logic [AW-1:0]  rem;
    logic           dir_q;
    logic           stage_lost;
    logic [SW-1:0]  s;

    assign s    = (rem > STEP_AMT) ? SW'(STEP) : rem[SW-1:0];
    assign busy = (state != IDLE);

    mont_shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .SW    (SW)
    ) u_stage (
        .acc     (acc),
        .dir     (dir_q),
        .s       (s),
        .shifted (stage_acc),
        .lost    (stage_lost)
    );

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            dir_q      <= DIR_LEFT;
            out_shift  <= '0;
            lost_bit   <= 1'b0;
            shift_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    shift_done <= 1'b0;
                    if (load) begin
                        acc <= {1'b0, in_number};
                    end
                    if (start) begin
                        dir_q    <= dir;
                        rem      <= (amount > MAX_AMT) ? MAX_AMT : amount;
                        lost_bit <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem == '0) begin
                        out_shift  <= acc;
                        shift_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        acc <= stage_acc;
                        rem <= rem - AW'(s);
                        if (dir_q == DIR_RIGHT) begin
                            lost_bit <= stage_lost;
                        end
                    end
                end
                DONE: begin
                    shift_done <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    shift_done <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_shift_unit.sv
// tb/tb_mont_shift_unit.sv - scoreboard bench for mont_shift_unit in 8-bit and 1024-bit builds
module tb_mont_shift_unit;

    typedef struct {
        logic [1024:0] out;
        logic          lb;
        int            issue;
        int            lat;
    } exp_t;

    typedef struct {
        int          u;
        logic [7:0]  v;
        logic        d;
        int          k;
        logic [8:0]  eo;
        logic        el;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic restn;
    logic ld0, st0, ld1, st1, ld2, st2;
    logic [7:0]    in8;
    logic [1023:0] in1k;
    logic          dir_c;
    logic [3:0]    amt4;
    logic [10:0]   amt11;

    logic          busy0, busy1, busy2;
    logic [8:0]    out0, out1;
    logic [1024:0] out2;
    logic          lb0, lb1, lb2;
    logic          dn0, dn1, dn2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    vec_t vt[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mont_shift_unit #(.WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .restn(restn), .load(ld0), .in_number(in8), .start(st0),
        .dir(dir_c), .amount(amt4), .busy(busy0), .out_shift(out0),
        .lost_bit(lb0), .shift_done(dn0)
    );

    mont_shift_unit #(.WIDTH(8), .STEP(4)) u1 (
        .clk(clk), .restn(restn), .load(ld1), .in_number(in8), .start(st1),
        .dir(dir_c), .amount(amt4), .busy(busy1), .out_shift(out1),
        .lost_bit(lb1), .shift_done(dn1)
    );

    mont_shift_unit #(.WIDTH(1024), .STEP(1)) u2 (
        .clk(clk), .restn(restn), .load(ld2), .in_number(in1k), .start(st2),
        .dir(dir_c), .amount(amt11), .busy(busy2), .out_shift(out2),
        .lost_bit(lb2), .shift_done(dn2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [1024:0] act, input logic [1024:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act[1024]=%b act[63:0]=%h exp[1024]=%b exp[63:0]=%h",
                     nm, act[1024], act[63:0], exp[1024], exp[63:0]);
        end
    endtask

    task automatic judge(input string nm, input logic [1024:0] o, input logic l, input exp_t e);
        chk_w({nm, ".out"}, o, e.out);
        chk({nm, ".lost"}, 64'(l), 64'(e.lb));
        chk({nm, ".lat"}, 64'(cyc - e.issue), 64'(e.lat));
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s.done act=1 exp=0 (no pending op)", nm);
    endtask

    always @(negedge clk) begin
        if (dn0 === 1'b1) begin
            if (q0.size() == 0) unexpected("u0");
            else begin e0 = q0.pop_front(); judge("u0", {1016'b0, out0}, lb0, e0); end
        end
        if (dn1 === 1'b1) begin
            if (q1.size() == 0) unexpected("u1");
            else begin e1 = q1.pop_front(); judge("u1", {1016'b0, out1}, lb1, e1); end
        end
        if (dn2 === 1'b1) begin
            if (q2.size() == 0) unexpected("u2");
            else begin e2 = q2.pop_front(); judge("u2", out2, lb2, e2); end
        end
    end

    task automatic issue(input int u, input logic ld, input logic [1023:0] val, input logic d,
                         input int k, input logic [1024:0] eo, input logic el, input int lat,
                         input bit push);
        exp_t e;
        @(negedge clk);
        in8   = val[7:0];
        in1k  = val;
        dir_c = d;
        amt4  = 4'(k);
        amt11 = 11'(k);
        e.out = eo; e.lb = el; e.issue = cyc + 1; e.lat = lat;
        case (u)
            0: begin ld0 = ld; st0 = 1'b1; if (push) q0.push_back(e); end
            1: begin ld1 = ld; st1 = 1'b1; if (push) q1.push_back(e); end
            default: begin ld2 = ld; st2 = 1'b1; if (push) q2.push_back(e); end
        endcase
        @(negedge clk);
        ld0 = 0; st0 = 0; ld1 = 0; st1 = 0; ld2 = 0; st2 = 0;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    initial begin
        logic [1024:0] w;
        logic [8:0]    prev;
        exp_t          e;
        int            n;

        restn = 1'b1;
        ld0 = 0; st0 = 0; ld1 = 0; st1 = 0; ld2 = 0; st2 = 0;
        in8 = '0; in1k = '0; dir_c = 0; amt4 = '0; amt11 = '0;

        vt[0]  = '{0, 8'hB4, 1'b0, 1,  9'h168, 1'b0, 2};
        vt[1]  = '{1, 8'h2D, 1'b1, 3,  9'h005, 1'b1, 2};
        vt[2]  = '{0, 8'h7F, 1'b0, 0,  9'h07F, 1'b0, 1};
        vt[3]  = '{0, 8'h7F, 1'b0, 15, 9'h000, 1'b0, 10};
        vt[4]  = '{1, 8'h7F, 1'b0, 15, 9'h000, 1'b0, 4};
        vt[5]  = '{1, 8'hB4, 1'b0, 5,  9'h080, 1'b0, 3};
        vt[6]  = '{1, 8'hFF, 1'b1, 8,  9'h000, 1'b1, 3};
        vt[7]  = '{0, 8'h81, 1'b1, 1,  9'h040, 1'b1, 2};
        vt[8]  = '{1, 8'h80, 1'b1, 9,  9'h000, 1'b0, 4};
        vt[9]  = '{1, 8'h55, 1'b1, 0,  9'h055, 1'b0, 1};
        vt[10] = '{0, 8'hFF, 1'b0, 8,  9'h100, 1'b0, 9};

        #1 restn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out0", 64'(out0), 64'd0);
        chk("rst.out1", 64'(out1), 64'd0);
        chk_w("rst.out2", out2, '0);
        chk("rst.busy", 64'({busy0, busy1, busy2}), 64'd0);
        chk("rst.done", 64'({dn0, dn1, dn2}), 64'd0);
        chk("rst.lost", 64'({lb0, lb1, lb2}), 64'd0);
        restn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(vt[i].u, 1'b1, {1016'b0, vt[i].v}, vt[i].d, vt[i].k,
                  {1016'b0, vt[i].eo}, vt[i].el, vt[i].lat, 1'b1);
            wait_drain(40);
        end

        // Collisions: busy-time load/start ignored, then back-to-back restart.
        prev = vt[10].eo;
        issue(0, 1'b1, 1024'h0F, 1'b0, 4, 1025'h0F0, 1'b0, 5, 1'b1);
        chk("hs.busy_rise", 64'(busy0), 64'd1);
        ld0 = 1'b1; st0 = 1'b1; in8 = 8'hAA; dir_c = 1'b1; amt4 = 4'd1;
        @(negedge clk);
        ld0 = 1'b0; st0 = 1'b0;
        chk("hs.out_hold", 64'(out0), 64'(prev));
        chk("hs.busy_hold", 64'(busy0), 64'd1);
        n = 0;
        while (dn0 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("hs.done_seen", 64'(dn0), 64'd1);
        chk("hs.acc", 64'(u0.acc), 64'h0F0);
        st0 = 1'b1; ld0 = 1'b0; dir_c = 1'b0; amt4 = 4'd1;
        e.out = 1025'h1E0; e.lb = 1'b0; e.issue = cyc + 2; e.lat = 2;
        q0.push_back(e);
        @(negedge clk);
        chk("hs.busy_fall", 64'(busy0), 64'd0);
        @(negedge clk);
        st0 = 1'b0;
        wait_drain(20);

        // Reset aborts a long left shift on the wide unit.
        w = '0; w[700] = 1'b1;
        issue(2, 1'b1, w[1023:0], 1'b0, 500, '0, 1'b0, 0, 1'b0);
        repeat (198) @(negedge clk);
        chk("ab.busy_pre", 64'(busy2), 64'd1);
        restn = 1'b0;
        #1;
        chk_w("ab.out2", out2, '0);
        chk("ab.busy2", 64'(busy2), 64'd0);
        chk("ab.state", 64'(u2.state), 64'(mont_shift_pkg::IDLE));
        chk("ab.lost", 64'({lb0, lb1, lb2}), 64'd0);
        chk("ab.out0", 64'(out0), 64'd0);
        chk("ab.out1", 64'(out1), 64'd0);
        @(negedge clk);
        restn = 1'b1;
        repeat (600) @(negedge clk);
        chk("ab.busy_after", 64'(busy2), 64'd0);

        // Chained Montgomery steps: x2 then /4 on 2^1023.
        w = '0; w[1023] = 1'b1;
        e.out = '0; e.out[1024] = 1'b1;
        issue(2, 1'b1, w[1023:0], 1'b0, 1, e.out, 1'b0, 2, 1'b1);
        wait_drain(20);
        e.out = '0; e.out[1022] = 1'b1;
        issue(2, 1'b0, '0, 1'b1, 2, e.out, 1'b0, 3, 1'b1);
        wait_drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
